// File: rtl/pll_reset_sequencer_pkg.sv
// pll_rst_pkg: sequencer state type and output widths shared by the PLL reset sequencer
package pll_rst_pkg;

    localparam int SEQ_STATE_W  = 2;
    localparam int RELOCK_CNT_W = 8;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } seq_state_e;

    // FAIL reports as PLL_RST on the 2-bit state port; it is flagged separately
    function automatic logic [SEQ_STATE_W-1:0] state_code(seq_state_e s);
        return (s == FAIL) ? '0 : SEQ_STATE_W'(s);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchroniser with asynchronous active-low clear
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // two back-to-back flops give a metastable first stage a full cycle to settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, waits for stable lock, releases the
// system reset and re-sequences on lock loss. Optional bounded retries with a
// sticky failure state are enabled by PLL_RESET_SEQUENCER_RETRY_LIMIT_EN.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 500000,
    parameter int LOCK_STABLE    = 1024,
    parameter int RELEASE_DELAY  = 256,
    parameter int LOSS_FILTER    = 4
`ifdef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
    ,
    parameter int MAX_RETRIES    = 3
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    output logic                    pll_rst,
    output logic                    sys_rst_n,
    output logic [SEQ_STATE_W-1:0]  seq_state,
    output logic [RELOCK_CNT_W-1:0] relock_cnt
`ifdef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
    ,
    output logic                    seq_fail
`endif
);

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B = (LOCK_STABLE > RELEASE_DELAY) ? LOCK_STABLE : RELEASE_DELAY;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_T = (MAX_C > LOSS_FILTER) ? MAX_C : LOSS_FILTER;
    localparam int CW    = $clog2(MAX_T) + 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'(RELEASE_DELAY - 1);
    localparam logic [CW-1:0] LOSS_LAST = CW'(LOSS_FILTER - 1);

    seq_state_e    state;
    seq_state_e    nxt;
    logic          lk_s;
    logic [CW-1:0] cnt;
    logic [CW-1:0] fcnt;
    logic          match;
    logic          give_up;

    sync_2ff #(.W(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    // the run-length counter tracks consecutive lock while waiting and consecutive loss while running
    assign match = (state == RUN) ? !lk_s : lk_s;

`ifdef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
    localparam int RW = $clog2(MAX_RETRIES + 2);
    logic [RW-1:0] tmo_cnt;

    assign give_up = int'(tmo_cnt) >= MAX_RETRIES;

    // consecutive lock timeouts; a successful release restores the full retry budget
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt  <= '0;
            seq_fail <= 1'b0;
        end else begin
            seq_fail <= (nxt == FAIL);
            tmo_cnt  <= (nxt == RUN) ? '0 :
                        (state == WAIT_LOCK && (nxt == PLL_RST || nxt == FAIL)) ? tmo_cnt + 1'b1 : tmo_cnt;
        end
    end
`else
    assign give_up = 1'b0;
`endif

    // next state: stable lock beats timeout, and lock loss during HOLD beats release
    always_comb begin
        nxt = state;
        case (state)
            PLL_RST:   nxt = (cnt == RST_LAST) ? WAIT_LOCK : PLL_RST;
            WAIT_LOCK: nxt = (lk_s && fcnt == STB_LAST) ? HOLD :
                             (cnt == TMO_LAST) ? (give_up ? FAIL : PLL_RST) : WAIT_LOCK;
            HOLD:      nxt = !lk_s ? PLL_RST : (cnt == REL_LAST) ? RUN : HOLD;
            RUN:       nxt = (!lk_s && fcnt == LOSS_LAST) ? PLL_RST : RUN;
            default:   nxt = state;
        endcase
    end

    // state, counters and every output register together so outputs change only on clock edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PLL_RST;
            cnt        <= '0;
            fcnt       <= '0;
            pll_rst    <= 1'b1;
            sys_rst_n  <= 1'b0;
            seq_state  <= '0;
            relock_cnt <= '0;
        end else begin
            state      <= nxt;
            cnt        <= (nxt != state) ? '0 : cnt + 1'b1;
            fcnt       <= (nxt != state || !match) ? '0 : fcnt + 1'b1;
            pll_rst    <= (nxt == PLL_RST) || (nxt == FAIL);
            sys_rst_n  <= (nxt == RUN);
            seq_state  <= state_code(nxt);
            if (state == RUN && nxt == PLL_RST && relock_cnt != '1)
                relock_cnt <= relock_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scoreboard bench; a phase-level model predicts every output change
module tb_pll_reset_sequencer;

    localparam int P_RST  = 4;
    localparam int T_LOCK = 50;
    localparam int N_STB  = 8;
    localparam int R_DLY  = 5;
    localparam int N_LOSS = 3;
    localparam int MAX_RT = 2;
    localparam int MAXN   = 1024;
`ifdef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif
    localparam logic [12:0] RST_V = {2'd0, 1'b1, 1'b0, 8'd0, 1'b0};

    typedef struct {
        int          e;
        logic [12:0] v;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic [1:0] seq_state;
    logic [7:0] relock_cnt;
    logic       fail_o;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         edge_n = 0;
    ev_t        exp_q[$];
    logic       lk [0:MAXN-1];

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (P_RST),
        .LOCK_TIMEOUT   (T_LOCK),
        .LOCK_STABLE    (N_STB),
        .RELEASE_DELAY  (R_DLY),
        .LOSS_FILTER    (N_LOSS)
`ifdef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
        ,
        .MAX_RETRIES    (MAX_RT)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .seq_state  (seq_state),
        .relock_cnt (relock_cnt)
`ifdef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
        ,
        .seq_fail   (fail_o)
`endif
    );

`ifndef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
    assign fail_o = 1'b0;
`endif

    always #10 clk = ~clk;

    // edge index since reset release; edge 1 is the first edge with rst_n high
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else edge_n <= edge_n + 1;
    end

    // synchronised lock as seen by the decision at edge k: lk[j] is driven after edge j
    function automatic logic lks(int k);
        return (k >= 3) ? lk[k-3] : 1'b0;
    endfunction

    function automatic bit steady(int hi, int len, logic v);
        for (int k = hi - len + 1; k <= hi; k++)
            if (lks(k) !== v) return 1'b0;
        return 1'b1;
    endfunction

    // phase 0 PLL_RST, 1 WAIT_LOCK, 2 HOLD, 3 RUN, 4 FAIL
    function automatic logic [12:0] outs(int ph, int rc);
        return {(ph == 4) ? 2'd0 : 2'(ph), ph == 0 || ph == 4, ph == 3, 8'(rc), ph == 4};
    endfunction

    // walk the lock waveform phase by phase and queue every output change up to edge n_end
    task automatic predict(int n_end);
        int t, ph, rc, tmo, e, nx;
        t = 0; ph = 0; rc = 0; tmo = 0;
        forever begin
            if (ph == 4) return;
            nx = -1;
            e = 0;
            if (ph == 0) begin
                e = t + P_RST;
                nx = 1;
            end else if (ph == 1) begin
                for (int k = t + N_STB; k <= t + T_LOCK && nx < 0; k++)
                    if (steady(k, N_STB, 1'b1)) begin e = k; nx = 2; end
                if (nx < 0) begin
                    e = t + T_LOCK;
                    tmo++;
                    nx = (LIMIT && tmo > MAX_RT) ? 4 : 0;
                end
            end else if (ph == 2) begin
                for (int k = t + 1; k <= t + R_DLY && nx < 0; k++)
                    if (lks(k) === 1'b0) begin e = k; nx = 0; end
                if (nx < 0) begin e = t + R_DLY; nx = 3; end
            end else begin
                for (int k = t + N_LOSS; k <= n_end && nx < 0; k++)
                    if (steady(k, N_LOSS, 1'b0)) begin e = k; nx = 0; end
                if (nx < 0) return;
                rc = (rc < 255) ? rc + 1 : 255;
            end
            if (e > n_end) return;
            if (nx == 3) tmo = 0;
            exp_q.push_back('{e, outs(nx, rc)});
            t = e;
            ph = nx;
        end
    endtask

    task automatic fill_after(int at);
        for (int j = 0; j < MAXN; j++) lk[j] = (j >= at);
    endtask

    task automatic fill_random();
        int j, len, kind;
        logic v;
        j = 0;
        while (j < MAXN) begin
            kind = $urandom_range(0, 3);
            v = (kind == 1 || kind == 2);
            len = (kind == 0) ? $urandom_range(5, 70) : (kind == 3) ? $urandom_range(1, 4) : $urandom_range(10, 90);
            for (int k = 0; k < len && j < MAXN; k++) begin
                lk[j] = v;
                j++;
            end
        end
    endtask

    // predict, release reset, play the waveform for n edges, then reset asynchronously mid-cycle
    task automatic run_scn(int n);
        predict(n);
        pll_locked = lk[0];
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= n; j++) begin
            @(posedge clk);
            #1;
            pll_locked = lk[j];
        end
        @(negedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: %0d expected output changes never seen, required 0 (next at edge %0d)",
                     exp_q.size(), exp_q[0].e);
            exp_q.delete();
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // monitor: checks reset values while rst_n is low, otherwise pops on every output change
    initial begin
        logic [12:0] prev;
        logic [12:0] cur;
        ev_t ev;
        prev = RST_V;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            cur = {seq_state, pll_rst, sys_rst_n, relock_cnt, fail_o};
            if (!rst_n) begin
                n_cmp++;
                if (cur !== RST_V) begin
                    n_bad++;
                    $display("FAIL reset: outputs=%h required %h", cur, RST_V);
                end
                prev = RST_V;
            end else if (cur !== prev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL change: unexpected outputs=%h at edge %0d, required no change from %h", cur, edge_n, prev);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.e != edge_n || ev.v !== cur) begin
                        n_bad++;
                        $display("FAIL change: outputs=%h at edge %0d, required %h at edge %0d", cur, edge_n, ev.v, ev.e);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        fill_after(14);
        run_scn(60);
        fill_after(14);
        run_scn(26);
        fill_after(14);
        run_scn(45);
        fill_after(MAXN);
        run_scn(200);
        fill_after(14);
        lk[40] = 1'b0; lk[41] = 1'b0;
        lk[60] = 1'b0; lk[61] = 1'b0; lk[62] = 1'b0;
        run_scn(120);
        for (int j = 0; j < MAXN; j++) lk[j] = (j % 7) != 6;
        run_scn(130);
        fill_after(14);
        lk[25] = 1'b0;
        run_scn(100);
        repeat (8) begin
            fill_random();
            run_scn($urandom_range(100, 500));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the four-output system PLL.
- Consumes the PLL `locked` flag and drives the PLL's active-high reset input.
- Generates the design-wide active-low system reset, released only after lock is stable.
- Runs on the free-running 50 MHz board reference clock, never on a PLL output. It also detects lock loss at runtime and re-sequences the PLL, with timeout-driven retries.

Parameters:
- PLL_RST_CYCLES, 16, cycles pll_rst is held high per PLL reset pulse (min 1)
- LOCK_TIMEOUT, 500000, cycles allowed in WAIT_LOCK before retrying (10 ms at 50 MHz)
- LOCK_STABLE, 1024, consecutive cycles of synchronised lock required before leaving WAIT_LOCK
- RELEASE_DELAY, 256, extra cycles sys_rst_n is held low after lock is declared stable
- LOSS_FILTER, 4, consecutive cycles of lost lock in RUN that trigger re-sequencing (min 1)
- MAX_RETRIES, 3, consecutive timeouts tolerated before FAIL (used only with the optional feature)

Ports:
- clk  input  1  50 MHz free-running reference clock
- rst_n  input  1  asynchronous active-low reset
- pll_locked  input  1  PLL lock flag; asynchronous to clk
- pll_rst  output  1  active-high reset to the PLL
- sys_rst_n  output  1  active-low reset to all PLL-clocked logic
- seq_state  output  2  current state: 0 PLL_RST, 1 WAIT_LOCK, 2 HOLD, 3 RUN
- relock_cnt  output  8  count of lock-loss events seen in RUN; saturates at 255
- seq_fail  output  1  sequencing failed; present only with the optional feature

Behaviour:
- Reset (rst_n low, asynchronous assert): pll_rst=1, sys_rst_n=0, seq_state=PLL_RST, relock_cnt=0, seq_fail=0. All counters and synchroniser flops clear to 0.
- Input sync: pll_locked passes through a 2-flop synchroniser to give lk_s. All decisions use lk_s, so there are 2 cycles of input latency.
- Counters: one shared down/up counter, sized by $clog2 of the largest timing parameter plus 1. It reloads on every state entry.
- PLL_RST:
  - pll_rst=1, sys_rst_n=0.
  - After PLL_RST_CYCLES cycles: go to WAIT_LOCK; pll_rst drops on the entry clock edge.
- WAIT_LOCK:
  - pll_rst=0, sys_rst_n=0.
  - Stable counter increments while lk_s=1 and clears to 0 on any cycle with lk_s=0.
  - Stable count reaches LOCK_STABLE: go to HOLD.
  - Otherwise, timeout counter reaches LOCK_TIMEOUT: go to PLL_RST (a retry).
  - Both conditions in the same cycle: HOLD wins.
- HOLD:
  - sys_rst_n=0.
  - lk_s=0 on any cycle: go to PLL_RST immediately.
  - After RELEASE_DELAY cycles: go to RUN; sys_rst_n rises on the entry edge.
- RUN:
  - sys_rst_n=1, pll_rst=0.
  - Loss counter counts consecutive cycles with lk_s=0 and clears when lk_s=1.
  - Loss counter reaches LOSS_FILTER: go to PLL_RST, sys_rst_n=0 on the same edge, relock_cnt+1 (saturating).
  - Glitches shorter than LOSS_FILTER cycles cause no action.
- Outputs are registered and glitch-free; sys_rst_n is driven directly from a flop.
- rst_n asserted mid-sequence: immediate return to reset values. relock_cnt is also cleared.

Optional Feature:
- Macro: PLL_RESET_SEQUENCER_RETRY_LIMIT_EN.
- With the macro defined:
  - A consecutive-timeout counter increments on each WAIT_LOCK timeout and clears on entry to RUN.
  - When it exceeds MAX_RETRIES, enter FAIL: pll_rst=1 and sys_rst_n=0 held, seq_fail=1, seq_state=0.
  - FAIL exits only via rst_n.
  - seq_fail port is present.
- Without the macro: retries are unbounded, the seq_fail port is absent, and there is no FAIL state.

Decomposition:
- Package pll_rst_pkg holds:
  - the state enum (PLL_RST, WAIT_LOCK, HOLD, RUN, FAIL)
  - the SEQ_STATE_W=2 constant
  - the RELOCK_CNT_W=8 constant
- One natural sub-module: sync_2ff, a generic 2-flop synchroniser with asynchronous active-low clear, used for pll_locked.

Test Plan:
- All tests use small parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=50, LOCK_STABLE=8, RELEASE_DELAY=5, LOSS_FILTER=3, MAX_RETRIES=2.
- Power-up, pll_locked rises 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst_n rises 2+8+5 cycles after pll_locked rises; seq_state reaches 3.
- pll_locked never rises -> pll_rst re-pulses every 4+50 cycles; with the macro, seq_fail=1 after the 3rd timeout and pll_rst is held high.
- In RUN, pll_locked low for 2 cycles -> no change, relock_cnt=0. Low for 3 cycles -> sys_rst_n=0 on the filter-expiry edge, relock_cnt=1, seq_state=0.
- In WAIT_LOCK, lock chatters (1 for 6 cycles, 0 for 1, repeated) -> never reaches HOLD; timeout retry occurs at 50 cycles.
- Lock drops for one cycle during HOLD -> immediate PLL_RST; sys_rst_n stays low throughout.
- rst_n pulsed low mid-HOLD and mid-RUN -> all outputs take reset values asynchronously; relock_cnt returns to 0; the sequence restarts cleanly.
